// File: rtl/tmds_pkg.sv
// Shared TMDS line codes, the lane disparity type and the small helpers used by
// every lane encoder.
package tmds_pkg;

  localparam logic [9:0] CTL_CODE_00 = 10'b1101010100;
  localparam logic [9:0] CTL_CODE_01 = 10'b0010101011;
  localparam logic [9:0] CTL_CODE_10 = 10'b0101010100;
  localparam logic [9:0] CTL_CODE_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_LANE0 = 10'b1011001100;
  localparam logic [9:0] GUARD_LANE1 = 10'b0100110011;
  localparam logic [9:0] GUARD_LANE2 = 10'b1011001100;

  localparam logic [9:0] CLK_PATTERN = 10'b0000011111;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int DELAY_LEN    = PREAMBLE_LEN + GUARD_LEN;

  typedef logic signed [4:0] disparity_t;

  typedef enum logic [1:0] {
    MODE_CTL   = 2'd0,
    MODE_DATA  = 2'd1,
    MODE_GUARD = 2'd2
  } lane_mode_e;

  // One input pixel as carried through the optional lookahead delay line
  typedef struct packed {
    logic       de;
    logic       hsync;
    logic       vsync;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pix_t;

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    logic [9:0] code;
    code = CTL_CODE_00;
    case (c)
      2'b00: code = CTL_CODE_00;
      2'b01: code = CTL_CODE_01;
      2'b10: code = CTL_CODE_10;
      2'b11: code = CTL_CODE_11;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: stage 1 builds the transition-minimised q_m word, stage 2
// applies DC balancing against the running disparity and registers the symbol.
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter logic [1:0] RST_CTL    = 2'b00,
  parameter logic [9:0] GUARD_CODE = GUARD_LANE0
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic [7:0] data,
  input  logic [1:0] ctl,
  output logic [9:0] tmds
);

  logic [3:0] n1_d;
  logic       use_xnor;
  logic [8:0] q_m;

  logic [8:0] q_m_reg;
  logic [1:0] mode_reg;
  logic [1:0] ctl_reg;

  logic [3:0] n1_q;
  logic [3:0] n0_q;
  disparity_t diff;
  disparity_t cnt_reg;
  disparity_t cnt_next;
  logic [9:0] tmds_reg;
  logic [9:0] tmds_next;

  always_comb begin
    n1_d     = ones8(data);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
    q_m      = '0;
    q_m[0]   = data[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
    q_m[8]   = ~use_xnor;
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      q_m_reg  <= '0;
      mode_reg <= MODE_CTL;
      ctl_reg  <= RST_CTL;
    end else begin
      q_m_reg  <= q_m;
      mode_reg <= mode;
      ctl_reg  <= ctl;
    end
  end

  // Non-data symbols are themselves balanced, so they restart the count at 0
  always_comb begin
    n1_q      = ones8(q_m_reg[7:0]);
    n0_q      = 4'd8 - n1_q;
    diff      = $signed({1'b0, n1_q}) - $signed({1'b0, n0_q});
    tmds_next = ctl_code(ctl_reg);
    cnt_next  = '0;
    case (mode_reg)
      MODE_DATA: begin
        if ((cnt_reg == '0) || (n1_q == n0_q)) begin
          tmds_next = {~q_m_reg[8], q_m_reg[8],
                       q_m_reg[8] ? q_m_reg[7:0] : ~q_m_reg[7:0]};
          cnt_next  = q_m_reg[8] ? cnt_reg + diff : cnt_reg - diff;
        end else if ((!cnt_reg[4] && (n1_q > n0_q)) ||
                     (cnt_reg[4] && (n0_q > n1_q))) begin
          tmds_next = {1'b1, q_m_reg[8], ~q_m_reg[7:0]};
          cnt_next  = cnt_reg + (q_m_reg[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
          tmds_next = {1'b0, q_m_reg[8], q_m_reg[7:0]};
          cnt_next  = cnt_reg + diff - (q_m_reg[8] ? 5'sd0 : 5'sd2);
        end
      end
      MODE_GUARD: tmds_next = GUARD_CODE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      tmds_reg <= ctl_code(RST_CTL);
      cnt_reg  <= '0;
    end else begin
      tmds_reg <= tmds_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign tmds = tmds_reg;

endmodule

// File: rtl/tmds_encoder_3ch.sv
// Three-lane DVI TMDS encoder plus clock lane. Defining TMDS_ENC_VIDEO_GUARD_EN
// adds a 10-word lookahead that inserts video preamble and guard band.
module tmds_encoder_3ch
  import tmds_pkg::*;
#(
  parameter logic [1:0] RST_CTL = 2'b00
) (
  input  logic            clk_pixel,
  input  logic            reset_n,
  input  logic [7:0]      red,
  input  logic [7:0]      green,
  input  logic [7:0]      blue,
  input  logic            de,
  input  logic            hsync,
  input  logic            vsync,
  output logic [3:0][9:0] tmds_par_out
);

  logic [2:0][7:0] lane_data;
  logic [2:0][1:0] lane_ctl;
  logic [1:0]      lane_mode;
  logic [2:0][9:0] lane_tmds;

`ifdef TMDS_ENC_VIDEO_GUARD_EN
  localparam pix_t PIX_RST = {1'b0, RST_CTL[0], RST_CTL[1], 24'h0};

  pix_t pix_in;
  pix_t dly_reg [DELAY_LEN];
  pix_t pix_old;
  logic guard_ahead;
  logic preamble_ahead;

  assign pix_in  = {de, hsync, vsync, red, green, blue};
  assign pix_old = dly_reg[DELAY_LEN-1];

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      for (int i = 0; i < DELAY_LEN; i++) dly_reg[i] <= PIX_RST;
    end else begin
      dly_reg[0] <= pix_in;
      for (int i = 1; i < DELAY_LEN; i++) dly_reg[i] <= dly_reg[i-1];
    end
  end

  // A blanking word whose de-rise is 1-2 words ahead is guard, 3-10 ahead is
  // preamble; short blanking therefore only ever loses preamble words.
  always_comb begin
    guard_ahead    = dly_reg[DELAY_LEN-2].de | dly_reg[DELAY_LEN-3].de;
    preamble_ahead = de;
    for (int i = 0; i < DELAY_LEN - GUARD_LEN; i++)
      preamble_ahead = preamble_ahead | dly_reg[i].de;
    lane_data[0] = pix_old.blue;
    lane_data[1] = pix_old.green;
    lane_data[2] = pix_old.red;
    lane_ctl[0]  = {pix_old.vsync, pix_old.hsync};
    lane_ctl[1]  = 2'b00;
    lane_ctl[2]  = 2'b00;
    lane_mode    = MODE_CTL;
    if (pix_old.de) begin
      lane_mode = MODE_DATA;
    end else if (guard_ahead) begin
      lane_mode = MODE_GUARD;
    end else if (preamble_ahead) begin
      lane_ctl[1] = 2'b01;
    end
  end
`else
  always_comb begin
    lane_data[0] = blue;
    lane_data[1] = green;
    lane_data[2] = red;
    lane_ctl[0]  = {vsync, hsync};
    lane_ctl[1]  = 2'b00;
    lane_ctl[2]  = 2'b00;
    lane_mode    = de ? MODE_DATA : MODE_CTL;
  end
`endif

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    tmds_channel_encoder #(
      .RST_CTL    ((gi == 0) ? RST_CTL : 2'b00),
      .GUARD_CODE ((gi == 0) ? GUARD_LANE0 :
                   (gi == 1) ? GUARD_LANE1 : GUARD_LANE2)
    ) u_enc (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .mode      (lane_mode),
      .data      (lane_data[gi]),
      .ctl       (lane_ctl[gi]),
      .tmds      (lane_tmds[gi])
    );
  end

  assign tmds_par_out = {CLK_PATTERN, lane_tmds};

endmodule
